// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG vector sequencer: controller states,
// default MISR settings and the per-vector cycle cost.
package atpg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_MISR_SEED = 32'h00000000;

    // FETCH + LOAD + CAPTURE plus the settle window.
    function automatic int cyclesPerVector(input int settleCycles);
        return 3 + settleCycles;
    endfunction

endpackage

// File: rtl/atpg_misr.sv
// Multiple-input signature register that compresses captured CUT responses.
// A load (start of a run) takes priority over a shift on the same cycle.
module atpg_misr
    import atpg_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEFAULT_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/atpg_vector_sequencer.sv
// Clocked, restartable controller that applies stored vectors to a combinational
// CUT, captures each response, checks it against expected data and signs it.
module atpg_vector_sequencer
    import atpg_pkg::*;
#(
    parameter int                  VEC_W         = 32,
    parameter int                  RESP_W        = 32,
    parameter int                  ADDR_W        = 5,
    parameter int                  SETTLE_CYCLES = 1,
    parameter logic [RESP_W-1:0]   MISR_POLY     = RESP_W'(DEFAULT_MISR_POLY),
    parameter logic [RESP_W-1:0]   MISR_SEED     = RESP_W'(DEFAULT_MISR_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_vec,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_rdata,
    input  logic [RESP_W-1:0] exp_rdata,
    output logic [VEC_W-1:0]  cut_in,
    input  logic [RESP_W-1:0] cut_out,
    output logic              resp_we,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [RESP_W-1:0] resp_wdata,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              fail_seen,
    output logic [ADDR_W-1:0] first_fail,
    output logic [RESP_W-1:0] signature
);

    localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
    localparam int              SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W:0]     n_q;
    logic [SET_W-1:0]    settleCnt_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   vecAddr_q;
    logic [VEC_W-1:0]    cutIn_q;
    logic [RESP_W-1:0]   exp_q;
    logic                capture_q;
    logic [ADDR_W:0]     failCnt_q;
    logic                failSeen_q;
    logic [ADDR_W-1:0]   firstFail_q;

    logic [ADDR_W:0]     numClamped_d;
    logic                busyState_d;
    logic                startAccept_d;
    logic                captureFire_d;
    logic                mismatch_d;
    logic                lastVec_d;

    // Abort always beats start, and start is only honoured from IDLE or DONE.
    always_comb begin
        numClamped_d  = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
        busyState_d   = (state_q != IDLE) && (state_q != DONE);
        startAccept_d = start && !abort && !busyState_d;
        captureFire_d = (state_q == CAPTURE) && !abort;
        mismatch_d    = (cut_out != exp_q);
        lastVec_d     = ({1'b0, idx_q} == (n_q - 1'b1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            settleCnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vecAddr_q   <= '0;
            cutIn_q     <= '0;
            exp_q       <= '0;
            capture_q   <= 1'b0;
            failCnt_q   <= '0;
            failSeen_q  <= 1'b0;
            firstFail_q <= '0;
        end else if (abort && busyState_d) begin
            // Partial counters and signature are deliberately kept for inspection.
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (startAccept_d) begin
                        idx_q       <= '0;
                        vecAddr_q   <= '0;
                        n_q         <= numClamped_d;
                        failCnt_q   <= '0;
                        failSeen_q  <= 1'b0;
                        firstFail_q <= '0;
                        if (numClamped_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    cutIn_q     <= vec_rdata;
                    exp_q       <= exp_rdata;
                    settleCnt_q <= '0;
                    state_q     <= (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
                    capture_q   <= (SETTLE_CYCLES == 0);
                end
                SETTLE: begin
                    if (int'(settleCnt_q) == SETTLE_CYCLES - 1) begin
                        state_q   <= CAPTURE;
                        capture_q <= 1'b1;
                    end else begin
                        settleCnt_q <= settleCnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    capture_q <= 1'b0;
                    if (mismatch_d) begin
                        if (failCnt_q != '1) begin
                            failCnt_q <= failCnt_q + 1'b1;
                        end
                        if (!failSeen_q) begin
                            failSeen_q  <= 1'b1;
                            firstFail_q <= idx_q;
                        end
                    end
                    if (lastVec_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        vecAddr_q <= idx_q + 1'b1;
                        state_q   <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    atpg_misr #(
        .WIDTH (RESP_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (startAccept_d),
        .seed    (MISR_SEED),
        .en      (captureFire_d),
        .data_in (cut_out),
        .sig     (signature)
    );

    // The CUT is combinational, so the response is written in the capture cycle itself.
    assign resp_we    = capture_q && !abort;
    assign resp_addr  = idx_q;
    assign resp_wdata = capture_q ? cut_out : '0;

    assign busy       = busy_q;
    assign done       = done_q;
    assign vec_addr   = vecAddr_q;
    assign cut_in     = cutIn_q;
    assign fail_cnt   = failCnt_q;
    assign fail_seen  = failSeen_q;
    assign first_fail = firstFail_q;

endmodule

// File: tb/tb_atpg_vector_sequencer.sv
// Directed, table-driven bench for the ATPG vector sequencer with a behavioural
// 16x16 multiplier CUT, synchronous vector/expected ROMs and a write logger.
module tb_atpg_vector_sequencer;

    localparam int VEC_W  = 32;
    localparam int RESP_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int BUDGET = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   num_vec;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] vec_addr;
    logic [VEC_W-1:0]  vec_rdata;
    logic [RESP_W-1:0] exp_rdata;
    logic [VEC_W-1:0]  cut_in;
    logic [RESP_W-1:0] cut_out;
    logic              resp_we;
    logic [ADDR_W-1:0] resp_addr;
    logic [RESP_W-1:0] resp_wdata;
    logic [ADDR_W:0]   fail_cnt;
    logic              fail_seen;
    logic [ADDR_W-1:0] first_fail;
    logic [RESP_W-1:0] signature;

    logic [31:0]       vecRom  [DEPTH];
    logic [31:0]       expGood [DEPTH];
    logic [31:0]       expRom  [DEPTH];
    logic [ADDR_W-1:0] wrAddr  [256];
    logic [31:0]       wrData  [256];
    int                wrCount = 0;
    int                checks = 0;
    int                failures = 0;

    typedef struct {
        logic [ADDR_W:0]   numVec;
        logic [31:0]       corruptMask;
        int                expWrites;
        logic [ADDR_W:0]   expFailCnt;
        logic              expFailSeen;
        logic [ADDR_W-1:0] expFirstFail;
        logic              checkSig;
        logic [31:0]       expSig;
    } run_t;

    run_t runTable [7];
    run_t cleanRun;

    atpg_vector_sequencer #(
        .VEC_W         (VEC_W),
        .RESP_W        (RESP_W),
        .ADDR_W        (ADDR_W),
        .SETTLE_CYCLES (1),
        .MISR_POLY     (32'h04C11DB7),
        .MISR_SEED     (32'h00000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .vec_addr   (vec_addr),
        .vec_rdata  (vec_rdata),
        .exp_rdata  (exp_rdata),
        .cut_in     (cut_in),
        .cut_out    (cut_out),
        .resp_we    (resp_we),
        .resp_addr  (resp_addr),
        .resp_wdata (resp_wdata),
        .fail_cnt   (fail_cnt),
        .fail_seen  (fail_seen),
        .first_fail (first_fail),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    // Behavioural c6288: upper half times lower half.
    assign cut_out = {16'b0, cut_in[31:16]} * {16'b0, cut_in[15:0]};

    always @(posedge clk) begin
        vec_rdata <= vecRom[vec_addr];
        exp_rdata <= expRom[vec_addr];
    end

    always @(posedge clk) begin
        if (resp_we) begin
            wrAddr[wrCount[7:0]] <= resp_addr;
            wrData[wrCount[7:0]] <= resp_wdata;
            wrCount <= wrCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W:0] n);
        @(negedge clk);
        num_vec = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},       32'(busy),       32'h0);
        checkOutput({tag, "_done"},       32'(done),       32'h0);
        checkOutput({tag, "_vec_addr"},   32'(vec_addr),   32'h0);
        checkOutput({tag, "_cut_in"},     cut_in,          32'h0);
        checkOutput({tag, "_resp_we"},    32'(resp_we),    32'h0);
        checkOutput({tag, "_resp_addr"},  32'(resp_addr),  32'h0);
        checkOutput({tag, "_resp_wdata"}, resp_wdata,      32'h0);
        checkOutput({tag, "_fail_cnt"},   32'(fail_cnt),   32'h0);
        checkOutput({tag, "_fail_seen"},  32'(fail_seen),  32'h0);
        checkOutput({tag, "_first_fail"}, 32'(first_fail), 32'h0);
        checkOutput({tag, "_signature"},  signature,       32'h0);
    endtask

    // Runs one record; injectAt >= 0 pulses start (num_vec=5) that many cycles into the run.
    task automatic runRecord(input run_t r, input string tag, input int injectAt);
        int base;
        int busyCycles;
        int waited;
        int got;
        for (int i = 0; i < DEPTH; i++) begin
            expRom[i] = r.corruptMask[i] ? (expGood[i] ^ 32'h1) : expGood[i];
        end
        base = wrCount;
        applyStimulus(r.numVec);
        busyCycles = 0;
        waited = 0;
        while (!done && waited < BUDGET) begin
            if (busy) busyCycles++;
            @(negedge clk);
            waited++;
            start = (waited == injectAt);
            if (waited == injectAt) num_vec = 6'd5;
        end
        start = 1'b0;
        checkOutput({tag, "_no_timeout"}, 32'(waited < BUDGET), 32'h1);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'(r.expWrites * 4));
        checkOutput({tag, "_busy_low"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h1);
        got = wrCount - base;
        checkOutput({tag, "_writes"}, 32'(got), 32'(r.expWrites));
        for (int k = 0; k < r.expWrites && k < got; k++) begin
            checkOutput($sformatf("%s_wr%0d_addr", tag, k), 32'(wrAddr[(base + k) % 256]), 32'(k));
            checkOutput($sformatf("%s_wr%0d_data", tag, k), wrData[(base + k) % 256], expGood[k]);
        end
        checkOutput({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(r.expFailCnt));
        checkOutput({tag, "_fail_seen"}, 32'(fail_seen), 32'(r.expFailSeen));
        checkOutput({tag, "_first_fail"}, 32'(first_fail), 32'(r.expFirstFail));
        if (r.checkSig) begin
            checkOutput({tag, "_signature"}, signature, r.expSig);
        end
    endtask

    initial begin
        int waited;
        int base;

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        num_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vecRom[i]  = {16'(i + 1), 16'(i + 2)};
            expGood[i] = (i + 1) * (i + 2);
        end
        vecRom[0]  = 32'h0003_0005;
        expGood[0] = 32'h0000_000F;
        vecRom[1]  = 32'hFFFF_FFFF;
        expGood[1] = 32'hFFFE_0001;
        for (int i = 0; i < DEPTH; i++) expRom[i] = expGood[i];

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // numVec, corruptMask, writes, failCnt, failSeen, firstFail, checkSig, signature
        runTable[0] = '{6'd2,  32'h0000_0000, 2,  6'd0, 1'b0, 5'd0, 1'b1, 32'hFFFE_001F};
        runTable[1] = '{6'd2,  32'h0000_0002, 2,  6'd1, 1'b1, 5'd1, 1'b1, 32'hFFFE_001F};
        runTable[2] = '{6'd0,  32'h0000_0000, 0,  6'd0, 1'b0, 5'd0, 1'b1, 32'h0000_0000};
        runTable[3] = '{6'd40, 32'h0000_0000, 32, 6'd0, 1'b0, 5'd0, 1'b0, 32'h0};
        runTable[4] = '{6'd3,  32'h0000_0005, 3,  6'd2, 1'b1, 5'd0, 1'b1, 32'hFB3D_1D85};
        runTable[5] = '{6'd1,  32'h0000_0000, 1,  6'd0, 1'b0, 5'd0, 1'b1, 32'h0000_000F};
        runTable[6] = '{6'd40, 32'h8000_0010, 32, 6'd2, 1'b1, 5'd4, 1'b0, 32'h0};
        cleanRun    = '{6'd2,  32'h0000_0000, 2,  6'd0, 1'b0, 5'd0, 1'b1, 32'hFFFE_001F};

        for (int t = 0; t < 7; t++) begin
            runRecord(runTable[t], $sformatf("run%0d", t), -1);
        end

        // Abort during the capture of vector 3 of an 8-vector run.
        for (int i = 0; i < DEPTH; i++) expRom[i] = (i == 1) ? (expGood[i] ^ 32'h1) : expGood[i];
        base = wrCount;
        applyStimulus(6'd8);
        waited = 0;
        while (!(resp_we && resp_addr == 5'd3) && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_reach_capture3", 32'(waited < BUDGET), 32'h1);
        abort = 1'b1;
        #1;
        checkOutput("abort_we_gated", 32'(resp_we), 32'h0);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        checkOutput("abort_writes", 32'(wrCount - base), 32'h3);
        checkOutput("abort_last_addr", 32'(wrAddr[(wrCount - 1) % 256]), 32'h2);
        checkOutput("abort_partial_fail_cnt", 32'(fail_cnt), 32'h1);
        checkOutput("abort_partial_first_fail", 32'(first_fail), 32'h1);
        repeat (5) @(negedge clk);
        checkOutput("abort_idle_writes", 32'(wrCount - base), 32'h3);
        checkOutput("abort_idle_busy", 32'(busy), 32'h0);
        runRecord(cleanRun, "after_abort", -1);

        // Reset in the middle of the settle window of the first vector.
        applyStimulus(6'd4);
        @(negedge clk);
        @(negedge clk);
        checkOutput("settle_busy", 32'(busy), 32'h1);
        checkOutput("settle_cut_in", cut_in, 32'h0003_0005);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        base = wrCount;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrst_no_writes", 32'(wrCount - base), 32'h0);
        checkOutput("midrst_idle_busy", 32'(busy), 32'h0);
        checkOutput("midrst_idle_done", 32'(done), 32'h0);

        // A start pulse while busy must not restart or resize the run.
        runRecord(cleanRun, "busy_start", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
